fetch_sequencer: RTL

Instruction-fetch and program-counter sequencer for the 16-bit single-cycle CPU. It sits on the supply side of the instruction decoder. It presents `INST` to the decoder from an asynchronous instruction ROM, then consumes the decoder's branch-select, offset and halt outputs plus the ALU flags to compute the next PC. It also owns the run/halt state machine and a retired-instruction counter used by the verification harness.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_sequencer_if.sv | 29 ++
 rtl/pc_next.sv | 35 +++
 rtl/fetch_sequencer.sv | 80 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared branch-select encodings, sequencer states and NOP word
package cpu_pkg;

  localparam logic [2:0] BS_BEQ  = 3'b000;
  localparam logic [2:0] BS_BNE  = 3'b001;
  localparam logic [2:0] BS_BGEZ = 3'b010;
  localparam logic [2:0] BS_JR   = 3'b011;
  localparam logic [2:0] BS_SEQ  = 3'b100;

  localparam logic [15:0] NOP_INST = 16'h0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - fetch sequencer bus: ROM word, decoder/ALU inputs, PC and fetch outputs
interface fetch_sequencer_if #(
  parameter int PC_W = 8
);
  logic [15:0]     IMEM_DATA;
  logic [2:0]      BS;
  logic [5:0]      OFF;
  logic            HALT;
  logic            Z;
  logic            N;
  logic [15:0]     RA_DATA;
  logic            STALL;
  logic            RESUME;
  logic [PC_W-1:0] PC;
  logic [15:0]     INST;
  logic            INST_VALID;
  logic            HALTED;
  logic [15:0]     RETIRED;

  modport master (
    output IMEM_DATA, BS, OFF, HALT, Z, N, RA_DATA, STALL, RESUME,
    input  PC, INST, INST_VALID, HALTED, RETIRED
  );

  modport slave (
    input  IMEM_DATA, BS, OFF, HALT, Z, N, RA_DATA, STALL, RESUME,
    output PC, INST, INST_VALID, HALTED, RETIRED
  );
endinterface

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-PC select; PC_W must be at least 6 for the offset sign-extension
module pc_next
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic [2:0]      bs_i,
  input  logic [5:0]      off_i,
  input  logic            z_i,
  input  logic            n_i,
  input  logic [PC_W-1:0] ra_i,
  output logic [PC_W-1:0] pc_inc_o,
  output logic [PC_W-1:0] pc_next_o
);

  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] tgt;

  assign off_ext  = {{(PC_W-6){off_i[5]}}, off_i};
  assign pc_inc_o = pc_i + 1'b1;
  assign tgt      = pc_inc_o + off_ext;

  always_comb begin
    pc_next_o = pc_inc_o;
    case (bs_i)
      BS_BEQ:  pc_next_o = z_i  ? tgt : pc_inc_o;
      BS_BNE:  pc_next_o = !z_i ? tgt : pc_inc_o;
      BS_BGEZ: pc_next_o = !n_i ? tgt : pc_inc_o;
      BS_JR:   pc_next_o = ra_i;
      default: pc_next_o = pc_inc_o;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - run/halt state, PC register, retired counter and INST bubble gating
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  fetch_sequencer_if.slave bus
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ret_q, ret_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_nxt;
  logic            inst_valid;

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc_i      (pc_q),
    .bs_i      (bus.BS),
    .off_i     (bus.OFF),
    .z_i       (bus.Z),
    .n_i       (bus.N),
    .ra_i      (bus.RA_DATA[PC_W-1:0]),
    .pc_inc_o  (pc_inc),
    .pc_next_o (pc_nxt)
  );

  // Jump-register targets only use the low PC_W bits of the register.
  if (PC_W < 16) begin : g_ra_hi
    logic unused_ra_hi;
    assign unused_ra_hi = ^bus.RA_DATA[15:PC_W];
  end

  assign inst_valid = (state_q == RUN) && !bus.STALL;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (!bus.STALL) begin
          ret_d = (ret_q == 16'hFFFF) ? ret_q : ret_q + 16'd1;
          if (bus.HALT) state_d = HALTED;
          else          pc_d    = pc_nxt;
        end
      end
      HALTED: begin
        // Resume steps past the halt instruction; STALL is irrelevant here.
        if (bus.RESUME) begin
          pc_d    = pc_inc;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= BOOT;
      pc_q    <= '0;
      ret_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.INST       = inst_valid ? bus.IMEM_DATA : NOP_INST;
  assign bus.INST_VALID = inst_valid;
  assign bus.HALTED     = (state_q == HALTED);
  assign bus.RETIRED    = ret_q;

endmodule
